// File: rtl/mips_processor.sv
// mips_processor: single-cycle 32-bit MIPS core with instruction ROM and data RAM.
// One instruction per rising edge; `out` holds the most recent register writeback.
// Optional feature: define MIPS_SHIFT_EN to implement sll/srl/sra (NOP otherwise).
// ROM contents are supplied externally; IMEM_FILE names the intended image.
module mips_processor #(
  parameter              IMEM_FILE = "program.hex",
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] out
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [31:0] pc;
  logic [31:0] rf   [32];
  logic [31:0] imem [MEM_WORDS];
  logic [31:0] dmem [MEM_WORDS];
  logic [1:0]  sync_q;
  logic        run;

  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_val, rt_val, sext, zext, ea, pc_plus4, br_target;
  logic [AW-1:0] mem_idx;

  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mem_we;
  logic [31:0] pc_next;

  // Reset release synchronizer; core executes only once this has run through
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end
  assign run = sync_q[1];

  assign instr     = imem[AW'(pc >> 2)];
  assign op        = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign funct     = instr[5:0];
  assign sext      = {{16{instr[15]}}, instr[15:0]};
  assign zext      = {16'h0000, instr[15:0]};
  assign rs_val    = rf[rs];
  assign rt_val    = rf[rt];
  assign ea        = rs_val + sext;
  assign mem_idx   = AW'(ea >> 2);
  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + {sext[29:0], 2'b00};

  // Decode and execute: next PC, writeback and store controls
  always_comb begin
    pc_next = pc_plus4;
    wb_en   = 1'b0;
    wb_addr = rt;
    wb_data = '0;
    mem_we  = 1'b0;
    case (op)
      OP_RTYPE: begin
        wb_addr = rd;
        case (funct)
          6'h20, 6'h21: begin wb_en = 1'b1; wb_data = rs_val + rt_val; end
          6'h22, 6'h23: begin wb_en = 1'b1; wb_data = rs_val - rt_val; end
          6'h24: begin wb_en = 1'b1; wb_data = rs_val & rt_val; end
          6'h25: begin wb_en = 1'b1; wb_data = rs_val | rt_val; end
          6'h26: begin wb_en = 1'b1; wb_data = rs_val ^ rt_val; end
          6'h27: begin wb_en = 1'b1; wb_data = ~(rs_val | rt_val); end
          6'h2A: begin wb_en = 1'b1; wb_data = 32'($signed(rs_val) < $signed(rt_val)); end
          6'h2B: begin wb_en = 1'b1; wb_data = 32'(rs_val < rt_val); end
          6'h08: pc_next = rs_val;
`ifdef MIPS_SHIFT_EN
          // all-zero word stays a true NOP rather than a write of $0
          6'h00: begin wb_en = (instr != 32'h0); wb_data = rt_val << instr[10:6]; end
          6'h02: begin wb_en = 1'b1; wb_data = rt_val >> instr[10:6]; end
          6'h03: begin wb_en = 1'b1; wb_data = 32'($signed(rt_val) >>> instr[10:6]); end
`endif
          default: ;
        endcase
      end
      OP_J:     pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
      OP_JAL: begin
        pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
        wb_en   = 1'b1;
        wb_addr = 5'd31;
        wb_data = pc_plus4;
      end
      OP_BEQ:   if (rs_val == rt_val) pc_next = br_target;
      OP_BNE:   if (rs_val != rt_val) pc_next = br_target;
      OP_ADDI, OP_ADDIU: begin wb_en = 1'b1; wb_data = rs_val + sext; end
      OP_SLTI:  begin wb_en = 1'b1; wb_data = 32'($signed(rs_val) < $signed(sext)); end
      OP_SLTIU: begin wb_en = 1'b1; wb_data = 32'(rs_val < sext); end
      OP_ANDI:  begin wb_en = 1'b1; wb_data = rs_val & zext; end
      OP_ORI:   begin wb_en = 1'b1; wb_data = rs_val | zext; end
      OP_XORI:  begin wb_en = 1'b1; wb_data = rs_val ^ zext; end
      OP_LUI:   begin wb_en = 1'b1; wb_data = {instr[15:0], 16'h0000}; end
      OP_LW:    begin wb_en = 1'b1; wb_data = dmem[mem_idx]; end
      OP_SW:    mem_we = 1'b1;
      default: ;
    endcase
  end

  // Architectural state update: PC, register file and observation register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= '0;
      out <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (run) begin
      pc <= pc_next;
      if (wb_en) begin
        out <= wb_data;
        if (wb_addr != 5'd0) rf[wb_addr] <= wb_data;
      end
    end
  end

  // Data RAM store port; contents survive reset
  always_ff @(posedge clk) begin
    if (run && mem_we) dmem[mem_idx] <= rt_val;
  end

endmodule

// File: tb/tb_mips_processor.sv
// Directed bench for mips_processor: preloads a program into ROM and checks
// `out` and PC after every executed instruction, then a mid-program reset.
module tb_mips_processor;

  logic        clk;
  logic        reset;
  logic [31:0] out;

  int total = 0;
  int bad   = 0;

  localparam int NSTEP = 30;

`ifdef MIPS_SHIFT_EN
  localparam logic [31:0] SRA_EXP = 32'hF800_0000;
  localparam logic [31:0] SRL_EXP = 32'h0800_0000;
`else
  localparam logic [31:0] SRA_EXP = 32'h8000_0000;
  localparam logic [31:0] SRL_EXP = 32'h8000_0000;
`endif

  logic [31:0] exp_out [NSTEP];
  logic [31:0] exp_pc  [NSTEP];

  mips_processor #(.IMEM_FILE(""), .MEM_WORDS(128)) dut (
    .clk   (clk),
    .reset (reset),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    dut.imem[addr[8:2]] = word;
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 128; i++) dut.imem[i] = 32'h0;

    put(32'h00, 32'h20010005); // addi $1,$0,5
    put(32'h04, 32'h2002FFFD); // addi $2,$0,-3
    put(32'h08, 32'h00221820); // add  $3,$1,$2
    put(32'h0C, 32'h0041202A); // slt  $4,$2,$1
    put(32'h10, 32'h0C000010); // jal  0x40
    put(32'h14, 32'h08000020); // j    0x80
    put(32'h40, 32'h3C051234); // lui  $5,0x1234
    put(32'h44, 32'h34A55678); // ori  $5,$5,0x5678
    put(32'h48, 32'h2C060001); // sltiu $6,$0,1
    put(32'h4C, 32'hAC050008); // sw   $5,8($0)
    put(32'h50, 32'h8C070008); // lw   $7,8($0)
    put(32'h54, 32'h2008020A); // addi $8,$0,0x20A
    put(32'h58, 32'h8D090000); // lw   $9,0($8)  aliases word 2
    put(32'h5C, 32'h10210002); // beq  $1,$1,+2
    put(32'h60, 32'h200A0111); // skipped
    put(32'h64, 32'h200A0222); // skipped
    put(32'h68, 32'h200A0333); // addi $10,$0,0x333
    put(32'h6C, 32'h14210001); // bne  $1,$1,+1 (falls through)
    put(32'h70, 32'h200B0444); // addi $11,$0,0x444
    put(32'h74, 32'h03E00008); // jr   $31
    put(32'h80, 32'h3C0C8000); // lui  $12,0x8000
    put(32'h84, 32'h000C6903); // sra  $13,$12,4
    put(32'h88, 32'h000C7102); // srl  $14,$12,4
    put(32'h8C, 32'h00227822); // sub  $15,$1,$2
    put(32'h90, 32'h00008027); // nor  $16,$0,$0
    put(32'h94, 32'h0022882B); // sltu $17,$1,$2
    put(32'h98, 32'h3832FFFF); // xori $18,$1,0xFFFF
    put(32'h9C, 32'h20000007); // addi $0,$0,7
    put(32'hA0, 32'h00009825); // or   $19,$0,$0
    put(32'hA4, 32'hFC000000); // unknown opcode
    put(32'hA8, 32'h20140055); // addi $20,$0,0x55
    put(32'hAC, 32'h0800002B); // j    0xAC (spin)

    exp_out = '{32'h5, 32'hFFFFFFFD, 32'h2, 32'h1, 32'h14,
                32'h12340000, 32'h12345678, 32'h1, 32'h1, 32'h12345678,
                32'h20A, 32'h12345678, 32'h12345678, 32'h333, 32'h333,
                32'h444, 32'h444, 32'h444, 32'h80000000, SRA_EXP,
                SRL_EXP, 32'h8, 32'hFFFFFFFF, 32'h1, 32'h0000FFFA,
                32'h7, 32'h0, 32'h0, 32'h55, 32'h55};
    exp_pc  = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h40,
                32'h44, 32'h48, 32'h4C, 32'h50, 32'h54,
                32'h58, 32'h5C, 32'h68, 32'h6C, 32'h70,
                32'h74, 32'h14, 32'h80, 32'h84, 32'h88,
                32'h8C, 32'h90, 32'h94, 32'h98, 32'h9C,
                32'hA0, 32'hA4, 32'hA8, 32'hAC, 32'hAC};

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    chk("rst_out", out, 32'h0);
    chk("rst_pc", dut.pc, 32'h0);
    reset = 1'b1;

    // Synchronizer edges: nothing executes yet
    repeat (2) @(posedge clk);
    #1;
    chk("sync_out", out, 32'h0);
    chk("sync_pc", dut.pc, 32'h0);

    for (int s = 0; s < NSTEP; s++) begin
      @(posedge clk);
      #1;
      chk($sformatf("out_step%0d", s), out, exp_out[s]);
      chk($sformatf("pc_step%0d", s), dut.pc, exp_pc[s]);
    end
    chk("r0_zero", dut.rf[0], 32'h0);
    chk("r10_beq_skip", dut.rf[10], 32'h333);

    // Mid-program reset: async clear, RAM retained
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_out", out, 32'h0);
    chk("midrst_pc", dut.pc, 32'h0);
    chk("midrst_r1", dut.rf[1], 32'h0);
    chk("midrst_ram", dut.dmem[2], 32'h12345678);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_hold", out, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rerun_sync", out, 32'h0);
    @(posedge clk);
    #1;
    chk("rerun_out", out, 32'h5);
    chk("rerun_pc", dut.pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
